// File: rtl/washer_pkg.sv
// Shared encodings for the programmable washer sequencer: states, program modes,
// fault codes and wash/rinse phase.
package washer_pkg;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_FILL    = 4'd1;
    localparam logic [3:0] S_AGITATE = 4'd2;
    localparam logic [3:0] S_DRAIN   = 4'd3;
    localparam logic [3:0] S_SPIN    = 4'd4;
    localparam logic [3:0] S_PAUSE   = 4'd5;
    localparam logic [3:0] S_ABORT   = 4'd6;
    localparam logic [3:0] S_DONE    = 4'd7;
    localparam logic [3:0] S_FAULT   = 4'd8;

    localparam logic [1:0] MODE_NORMAL = 2'b00;
    localparam logic [1:0] MODE_QUICK  = 2'b01;
    localparam logic [1:0] MODE_HEAVY  = 2'b10;
    localparam logic [1:0] MODE_RINSE  = 2'b11;

    localparam logic [2:0] FC_NONE  = 3'd0;
    localparam logic [2:0] FC_FILL  = 3'd1;
    localparam logic [2:0] FC_DRAIN = 3'd2;
    localparam logic [2:0] FC_DOOR  = 3'd3;

    typedef enum logic {PH_WASH = 1'b0, PH_RINSE = 1'b1} phase_t;

    function automatic logic is_busy(input logic [3:0] s);
        return !(s == S_IDLE || s == S_DONE || s == S_FAULT);
    endfunction

endpackage

// File: rtl/washer_ctrl_prog_timer.sv
// Phase timer: clears on state change, freezes while paused, saturates at all-ones,
// and flags when the count equals the limit selected by the controller.
module washer_phase_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             hold,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             at_limit
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (!hold && count != '1) begin
            count <= count + 1'b1;
        end
    end

    assign at_limit = (count == limit);

endmodule

// File: rtl/washer_ctrl_prog.sv
// Programmable washer sequencer: program latch, rinse pass counter, pause/resume,
// cancel-with-drain and coded faults around a single Moore FSM.
module washer_ctrl_prog
    import washer_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int WASH_T    = 1000,
    parameter int RINSE_T   = 400,
    parameter int SPIN_MIN  = 200,
    parameter int SPIN_T    = 800,
    parameter int FILL_TO   = 500,
    parameter int DRAIN_TO  = 500,
    parameter int HEAVY_RIN = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic       door_open,
    input  logic       water_full,
    input  logic       drained,
    input  logic       dry_sensor,
    input  logic       cancel,
    output logic       water_fill,
    output logic       motor_wash,
    output logic       motor_spin,
    output logic       drain,
    output logic       door_lock,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [3:0] state_o
);

    localparam logic [CNT_W-1:0] FILL_LIM  = CNT_W'(FILL_TO - 1);
    localparam logic [CNT_W-1:0] DRAIN_LIM = CNT_W'(DRAIN_TO - 1);
    localparam logic [CNT_W-1:0] SPIN_LIM  = CNT_W'(SPIN_T - 1);
    localparam logic [CNT_W-1:0] RINSE_LEN = CNT_W'(RINSE_T);
    localparam logic [CNT_W-1:0] SPIN_MN   = CNT_W'(SPIN_MIN);

    logic [3:0]       state, state_nx, resume_state;
    logic [2:0]       fc_nx, rinse_left;
    phase_t           phase;
    logic [CNT_W-1:0] wash_len, agit_len, limit, count;
    logic             at_limit, tmr_clr, tmr_hold;

    assign agit_len = (phase == PH_WASH) ? wash_len : RINSE_LEN;

    always_comb begin
        limit = '1;
        case (state)
            S_FILL:           limit = FILL_LIM;
            S_AGITATE:        limit = agit_len - 1'b1;
            S_DRAIN, S_ABORT: limit = DRAIN_LIM;
            S_SPIN:           limit = SPIN_LIM;
            default:          limit = '1;
        endcase
    end

    // Priority inside each state: cancel, then door, then success, then timeout.
    always_comb begin
        state_nx = state;
        fc_nx    = fault_code;
        case (state)
            S_IDLE: if (start && !door_open && !cancel) state_nx = S_FILL;
            S_FILL: begin
                if (cancel)          state_nx = S_ABORT;
                else if (door_open)  state_nx = S_PAUSE;
                else if (water_full) state_nx = S_AGITATE;
                else if (at_limit) begin state_nx = S_FAULT; fc_nx = FC_FILL; end
            end
            S_AGITATE: begin
                if (cancel)         state_nx = S_ABORT;
                else if (door_open) state_nx = S_PAUSE;
                else if (at_limit)  state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (cancel)         state_nx = S_ABORT;
                else if (door_open) begin state_nx = S_FAULT; fc_nx = FC_DOOR; end
                else if (drained)   state_nx = (rinse_left != 3'd0) ? S_FILL : S_SPIN;
                else if (at_limit)  begin state_nx = S_FAULT; fc_nx = FC_DRAIN; end
            end
            S_SPIN: begin
                if (cancel)         state_nx = S_ABORT;
                else if (door_open) begin state_nx = S_FAULT; fc_nx = FC_DOOR; end
                else if ((dry_sensor && count >= SPIN_MN) || at_limit) state_nx = S_DONE;
            end
            S_PAUSE: begin
                if (cancel)                     state_nx = S_ABORT;
                else if (start && !door_open)   state_nx = resume_state;
            end
            S_ABORT: begin
                if (drained)       state_nx = S_IDLE;
                else if (at_limit) begin state_nx = S_FAULT; fc_nx = FC_DRAIN; end
            end
            S_DONE:  state_nx = S_IDLE;
            S_FAULT: if (cancel && drained) begin state_nx = S_IDLE; fc_nx = FC_NONE; end
            default: state_nx = S_IDLE;
        endcase
    end

    // Pause entry and resume keep the count; every other transition restarts it.
    assign tmr_hold = (state == S_PAUSE) || (state_nx == S_PAUSE);
    assign tmr_clr  = (state_nx != state) && (state_nx != S_PAUSE) &&
                      !(state == S_PAUSE && state_nx != S_ABORT);

    washer_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (tmr_clr),
        .hold     (tmr_hold),
        .limit    (limit),
        .count    (count),
        .at_limit (at_limit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            resume_state <= S_FILL;
            fault_code   <= FC_NONE;
            rinse_left   <= 3'd0;
            phase        <= PH_WASH;
            wash_len     <= '0;
        end else begin
            state      <= state_nx;
            fault_code <= fc_nx;
            if (state_nx == S_PAUSE && state != S_PAUSE) resume_state <= state;
            if (state == S_IDLE && state_nx == S_FILL) begin
                phase <= (mode == MODE_RINSE) ? PH_RINSE : PH_WASH;
                case (mode)
                    MODE_HEAVY: begin rinse_left <= 3'(HEAVY_RIN); wash_len <= CNT_W'(WASH_T * 2); end
                    MODE_QUICK: begin rinse_left <= 3'd1; wash_len <= CNT_W'(WASH_T / 2); end
                    MODE_RINSE: begin rinse_left <= 3'd0; wash_len <= CNT_W'(WASH_T); end
                    default:    begin rinse_left <= 3'd1; wash_len <= CNT_W'(WASH_T); end
                endcase
            end else if (state == S_DRAIN && state_nx == S_FILL) begin
                rinse_left <= rinse_left - 3'd1;
                phase      <= PH_RINSE;
            end
        end
    end

    always_comb begin
        water_fill = (state == S_FILL);
        motor_wash = (state == S_AGITATE);
        motor_spin = (state == S_SPIN);
        drain      = (state == S_DRAIN) || (state == S_SPIN) || (state == S_ABORT);
        door_lock  = 1'b0;
        case (state)
            S_FILL, S_AGITATE, S_DRAIN, S_SPIN, S_ABORT: door_lock = 1'b1;
            S_PAUSE, S_FAULT:                            door_lock = !drained;
            default:                                     door_lock = 1'b0;
        endcase
        busy    = is_busy(state);
        done    = (state == S_DONE);
        fault   = (state == S_FAULT);
        state_o = state;
    end

endmodule

// File: tb/tb_washer_ctrl_prog.sv
// Directed bench for washer_ctrl_prog: a vector table for a full quick program
// plus hand-written sequences for pause, faults, cancel, early dry and reset.
module tb_washer_ctrl_prog;
    import washer_pkg::*;

    logic       clk = 1'b0;
    logic       rst, start, door_open, water_full, drained, dry_sensor, cancel;
    logic [1:0] mode;
    logic       water_fill, motor_wash, motor_spin, drain, door_lock, busy, done, fault;
    logic [2:0] fault_code;
    logic [3:0] state_o;
    logic [7:0] outs;

    localparam logic [7:0] O_IDLE  = 8'b0000_0000;
    localparam logic [7:0] O_FILL  = 8'b1000_1100;
    localparam logic [7:0] O_AG    = 8'b0100_1100;
    localparam logic [7:0] O_DRAIN = 8'b0001_1100;
    localparam logic [7:0] O_SPIN  = 8'b0011_1100;
    localparam logic [7:0] O_DONE  = 8'b0000_0010;

    typedef struct {
        logic       st;
        logic [1:0] md;
        logic       door, full, drn, dry, cnl;
        logic [3:0] exp_state;
        logic [7:0] exp_out;
    } vec_t;

    vec_t       vec_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         n_chk = 0;
    int         n_fail = 0;

    washer_ctrl_prog #(
        .CNT_W(8), .WASH_T(8), .RINSE_T(4), .SPIN_MIN(3), .SPIN_T(6),
        .FILL_TO(5), .DRAIN_TO(5), .HEAVY_RIN(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .door_open(door_open),
        .water_full(water_full), .drained(drained), .dry_sensor(dry_sensor), .cancel(cancel),
        .water_fill(water_fill), .motor_wash(motor_wash), .motor_spin(motor_spin),
        .drain(drain), .door_lock(door_lock), .busy(busy), .done(done), .fault(fault),
        .fault_code(fault_code), .state_o(state_o)
    );

    assign outs = {water_fill, motor_wash, motor_spin, drain, door_lock, busy, done, fault};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int n, input logic st, input logic [1:0] md, input logic door,
                        input logic full, input logic drn, input logic dry, input logic cnl,
                        input logic [3:0] es, input logic [7:0] eo);
        vec_t v;
        v.st = st; v.md = md; v.door = door; v.full = full; v.drn = drn;
        v.dry = dry; v.cnl = cnl; v.exp_state = es; v.exp_out = eo;
        for (int i = 0; i < n; i++) vec_q.push_back(v);
    endtask

    // Drives sensors automatically (success on the 2nd cycle of FILL/DRAIN) until tgt.
    task automatic advance_to(input logic [3:0] tgt, input int budget);
        logic [3:0] prev;
        int         in_st;
        bit         hit;
        prev = state_o; in_st = 0; hit = 0;
        for (int c = 0; c < budget; c++) begin
            water_full = (state_o == S_FILL) && (in_st >= 1);
            drained    = (state_o == S_DRAIN) && (in_st >= 1);
            tick;
            in_st = (state_o == prev) ? in_st + 1 : 0;
            prev  = state_o;
            if (state_o == tgt) begin hit = 1; break; end
        end
        water_full = 0; drained = 0;
        chk("advance_reached", 32'(hit), 32'd1);
    endtask

    task automatic auto_run(input logic [1:0] m, output int spin_n, output int done_n, output bit ok);
        logic [3:0] prev;
        int         in_st, ag_n;
        got_q.delete();
        spin_n = 0; done_n = 0; ok = 0; ag_n = 0; in_st = 0;
        mode = m; start = 1; tick; start = 0;
        mode = ~m;
        prev = state_o;
        for (int c = 0; c < 300; c++) begin
            water_full = (state_o == S_FILL) && (in_st >= 1);
            drained    = (state_o == S_DRAIN) && (in_st >= 1);
            tick;
            in_st = (state_o == prev) ? in_st + 1 : 0;
            if (state_o == S_AGITATE) ag_n++;
            else if (prev == S_AGITATE) begin got_q.push_back(8'(ag_n)); ag_n = 0; end
            if (state_o == S_SPIN) spin_n++;
            if (done) done_n++;
            prev = state_o;
            if (state_o == S_IDLE) begin ok = 1; break; end
        end
        water_full = 0; drained = 0;
    endtask

    task automatic check_program(input string name, input logic [1:0] m);
        int spin_n, done_n;
        bit ok;
        auto_run(m, spin_n, done_n, ok);
        chk({name, "_finished"}, 32'(ok), 32'd1);
        chk({name, "_agitate_passes"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({name, "_agitate_len"}, 32'(got_q[i]), 32'(exp_q[i]));
        chk({name, "_spin_cycles"}, 32'(spin_n), 32'd6);
        chk({name, "_done_pulses"}, 32'(done_n), 32'd1);
    endtask

    initial begin
        rst = 1; start = 0; mode = 2'b00; door_open = 0; water_full = 0;
        drained = 0; dry_sensor = 0; cancel = 0;
        tick; tick;
        chk("reset_state", 32'(state_o), 32'(S_IDLE));
        chk("reset_outputs", 32'(outs), 32'(O_IDLE));
        chk("reset_fault_code", 32'(fault_code), 32'd0);
        rst = 0;

        // Quick program; mode flips to heavy mid-run and must be ignored.
        push(1, 1, 2'b01, 1, 0, 0, 0, 0, S_IDLE, O_IDLE);
        push(1, 1, 2'b01, 0, 0, 0, 0, 1, S_IDLE, O_IDLE);
        push(1, 1, 2'b01, 0, 0, 0, 0, 0, S_FILL, O_FILL);
        push(1, 0, 2'b10, 0, 0, 0, 0, 0, S_FILL, O_FILL);
        push(1, 0, 2'b10, 0, 1, 0, 0, 0, S_AGITATE, O_AG);
        push(3, 0, 2'b10, 0, 0, 0, 0, 0, S_AGITATE, O_AG);
        push(1, 0, 2'b10, 0, 0, 0, 0, 0, S_DRAIN, O_DRAIN);
        push(1, 0, 2'b10, 0, 0, 0, 0, 0, S_DRAIN, O_DRAIN);
        push(1, 0, 2'b10, 0, 0, 1, 0, 0, S_FILL, O_FILL);
        push(1, 0, 2'b10, 0, 0, 0, 0, 0, S_FILL, O_FILL);
        push(1, 0, 2'b10, 0, 1, 0, 0, 0, S_AGITATE, O_AG);
        push(3, 0, 2'b10, 0, 0, 0, 0, 0, S_AGITATE, O_AG);
        push(1, 0, 2'b10, 0, 0, 0, 0, 0, S_DRAIN, O_DRAIN);
        push(1, 0, 2'b10, 0, 0, 0, 0, 0, S_DRAIN, O_DRAIN);
        push(1, 0, 2'b10, 0, 0, 1, 0, 0, S_SPIN, O_SPIN);
        push(5, 0, 2'b10, 0, 0, 1, 0, 0, S_SPIN, O_SPIN);
        push(1, 0, 2'b10, 0, 0, 1, 0, 0, S_DONE, O_DONE);
        push(1, 0, 2'b10, 0, 0, 0, 0, 0, S_IDLE, O_IDLE);
        for (int i = 0; i < vec_q.size(); i++) begin
            start = vec_q[i].st; mode = vec_q[i].md; door_open = vec_q[i].door;
            water_full = vec_q[i].full; drained = vec_q[i].drn;
            dry_sensor = vec_q[i].dry; cancel = vec_q[i].cnl;
            tick;
            chk($sformatf("vec%0d_state", i), 32'(state_o), 32'(vec_q[i].exp_state));
            chk($sformatf("vec%0d_outs", i), 32'(outs), 32'(vec_q[i].exp_out));
        end
        start = 0; water_full = 0; drained = 0;

        exp_q = '{8'd8, 8'd4};        check_program("normal", 2'b00);
        exp_q = '{8'd16, 8'd4, 8'd4}; check_program("heavy", 2'b10);
        exp_q = '{8'd4, 8'd4};        check_program("quick", 2'b01);
        exp_q = '{8'd4};              check_program("rinse_spin", 2'b11);

        // Fill timeout, then fault recovery only with cancel and drained together.
        mode = 2'b00; start = 1; tick; start = 0;
        repeat (4) tick;
        chk("fill_to_still_fill", 32'(state_o), 32'(S_FILL));
        tick;
        chk("fill_to_state", 32'(state_o), 32'(S_FAULT));
        chk("fill_to_code", 32'(fault_code), 32'd1);
        chk("fill_to_outs", 32'(outs), 32'b0000_1001);
        drained = 1; #1;
        chk("fault_lock_drained", 32'(door_lock), 32'd0);
        drained = 0; cancel = 1; tick;
        chk("fault_hold_undrained", 32'(state_o), 32'(S_FAULT));
        drained = 1; tick;
        chk("fault_clear_state", 32'(state_o), 32'(S_IDLE));
        chk("fault_clear_code", 32'(fault_code), 32'd0);
        cancel = 0; drained = 0;

        // Pause at agitate timer 3; resume completes 5 more agitate cycles.
        start = 1; tick; start = 0;
        water_full = 1; tick; water_full = 0;
        repeat (3) tick;
        door_open = 1; tick;
        chk("pause_state", 32'(state_o), 32'(S_PAUSE));
        chk("pause_outs", 32'(outs), 32'b0000_1100);
        drained = 1; #1;
        chk("pause_lock_drained", 32'(door_lock), 32'd0);
        drained = 0; tick;
        door_open = 0; tick;
        chk("pause_needs_start", 32'(state_o), 32'(S_PAUSE));
        start = 1; tick; start = 0;
        chk("resume_state", 32'(state_o), 32'(S_AGITATE));
        for (int i = 0; i < 5; i++) begin
            tick;
            chk($sformatf("resume_cyc%0d", i), 32'(state_o), (i < 4) ? 32'(S_AGITATE) : 32'(S_DRAIN));
        end
        cancel = 1; tick; cancel = 0;
        chk("drain_cancel_abort", 32'(state_o), 32'(S_ABORT));
        drained = 1; tick; drained = 0;
        chk("abort_to_idle", 32'(state_o), 32'(S_IDLE));

        // Door opened during spin.
        mode = 2'b11; start = 1; tick; start = 0;
        advance_to(S_SPIN, 40);
        door_open = 1; tick; door_open = 0;
        chk("door_spin_state", 32'(state_o), 32'(S_FAULT));
        chk("door_spin_code", 32'(fault_code), 32'd3);
        chk("door_spin_motor", 32'(motor_spin), 32'd0);
        cancel = 1; drained = 1; tick; cancel = 0; drained = 0;
        chk("door_spin_clear", 32'(state_o), 32'(S_IDLE));

        // Drain timeout.
        start = 1; tick; start = 0;
        advance_to(S_DRAIN, 40);
        repeat (4) tick;
        chk("drain_to_still_drain", 32'(state_o), 32'(S_DRAIN));
        tick;
        chk("drain_to_state", 32'(state_o), 32'(S_FAULT));
        chk("drain_to_code", 32'(fault_code), 32'd2);
        cancel = 1; drained = 1; tick; cancel = 0; drained = 0;

        // Cancel during fill drains until empty.
        mode = 2'b00; start = 1; tick; start = 0;
        cancel = 1; tick; cancel = 0;
        chk("cancel_fill_state", 32'(state_o), 32'(S_ABORT));
        chk("cancel_fill_outs", 32'(outs), 32'b0001_1100);
        door_open = 1; tick; door_open = 0;
        chk("abort_ignores_door", 32'(state_o), 32'(S_ABORT));
        drained = 1; tick; drained = 0;
        chk("abort_idle_state", 32'(state_o), 32'(S_IDLE));
        chk("abort_idle_drain", 32'(drain), 32'd0);

        // Dry sensor below SPIN_MIN ignored; start held across DONE.
        mode = 2'b11; start = 1; tick; start = 0;
        advance_to(S_SPIN, 40);
        tick;
        dry_sensor = 1; start = 1;
        tick;
        chk("dry_t1_ignored", 32'(state_o), 32'(S_SPIN));
        tick;
        chk("dry_t2_ignored", 32'(state_o), 32'(S_SPIN));
        tick;
        chk("dry_t3_done", 32'(state_o), 32'(S_DONE));
        chk("dry_done_pulse", 32'(done), 32'd1);
        tick;
        chk("done_to_idle", 32'(state_o), 32'(S_IDLE));
        chk("done_pulse_end", 32'(done), 32'd0);
        tick;
        chk("start_held_retrigger", 32'(state_o), 32'(S_FILL));
        start = 0; dry_sensor = 0;
        cancel = 1; tick; cancel = 0;
        drained = 1; tick; drained = 0;

        // Reset mid-agitate.
        mode = 2'b00; start = 1; tick; start = 0;
        water_full = 1; tick; water_full = 0;
        tick; tick;
        chk("pre_rst_agitate", 32'(state_o), 32'(S_AGITATE));
        rst = 1; tick; rst = 0;
        chk("rst_mid_state", 32'(state_o), 32'(S_IDLE));
        chk("rst_mid_outs", 32'(outs), 32'(O_IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
